// File: rtl/mem_read_rr_arbiter.sv
// mem_read_rr_arbiter
//   Shares one packet-memory read port between N read controllers.
//   Work-conserving round-robin grant (idle ports skipped) with an optional
//   burst credit of up to MAX_BURST consecutive grants per port. A tag
//   pipeline, READ_LAT deep, routes each read response back to the port that
//   issued the read. A sticky error flag reports responses and tags that do
//   not line up.
//
// Ports
//   clk           clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   mem_re_i      [N] read request per port, held until granted
//   mem_raddr_i   [N*ADDR_W] read address per port, port p at [p*ADDR_W +: ADDR_W]
//   mem_gnt_o     [N] one-hot grant, same cycle as the request
//   mem_ready_i   memory can accept a read this cycle
//   mem_re_o      read enable to memory
//   mem_raddr_o   read address to memory (0 when idle)
//   mem_rvalid_i  read data valid from memory
//   mem_rdata_i   read data from memory
//   mem_rvalid_o  [N] per-port response valid
//   mem_rdata_o   shared response data, passed straight through
//   ptr_o         current priority pointer (debug)
//   err_o         sticky response/tag mismatch flag
module mem_read_rr_arbiter #(
  parameter int N          = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 512,
  parameter int READ_LAT   = 1,
  parameter int MAX_BURST  = 1,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          mem_re_i,
  input  logic [N*ADDR_W-1:0]   mem_raddr_i,
  output logic [N-1:0]          mem_gnt_o,
  input  logic                  mem_ready_i,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_raddr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [N-1:0]          mem_rvalid_o,
  output logic [BLOCK_BITS-1:0] mem_rdata_o,
  output logic [IDX_W-1:0]      ptr_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0]   NUM_PORTS = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_burst;
  logic             r_err;
  logic             r_tag_v [READ_LAT];
  logic [IDX_W-1:0] r_tag_p [READ_LAT];

  logic             w_found;
  logic [IDX_W-1:0] w_gidx;
  logic [IDX_W:0]   w_sum;
  logic             w_grant;
  logic [CNT_W-1:0] w_n;
  logic             w_tag_v;
  logic [IDX_W-1:0] w_tag_p;

  // Cyclic scan starting at the pointer; the first requester wins.
  // r_ptr < N, so ptr+k < 2N and one conditional subtract gives mod N.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NUM_PORTS) begin
        w_sum = w_sum - NUM_PORTS;
      end
      if (!w_found && mem_re_i[w_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[IDX_W-1:0];
      end
    end
  end

  // Grant is gated by rst_n so nothing reaches memory while reset is held.
  assign w_grant     = w_found & mem_ready_i & rst_n;
  assign mem_re_o    = w_grant;
  assign mem_gnt_o   = w_grant ? (ONE_HOT0 << w_gidx) : '0;
  assign mem_raddr_o = w_grant ? mem_raddr_i[w_gidx*ADDR_W +: ADDR_W] : '0;

  // Burst credit: consecutive grants to the pointer port accumulate; once
  // the credit is used up the pointer moves past the granted port.
  assign w_n = (w_gidx == r_ptr) ? (r_burst + CNT_W'(1)) : CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_burst <= '0;
    end else if (w_grant) begin
      if (w_n >= BURST_MAX) begin
        r_ptr   <= (w_gidx == LAST_IDX) ? '0 : (w_gidx + IDX_W'(1));
        r_burst <= '0;
      end else begin
        r_ptr   <= w_gidx;
        r_burst <= w_n;
      end
    end
  end

  // Tag pipeline: one {valid, port} entry per cycle of memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_p[i] <= '0;
      end
    end else begin
      r_tag_v[0] <= w_grant;
      r_tag_p[0] <= w_gidx;
      for (int i = 1; i < READ_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign w_tag_v = r_tag_v[READ_LAT-1];
  assign w_tag_p = r_tag_p[READ_LAT-1];

  // A response with no tag is dropped here (valid stays low).
  assign mem_rvalid_o = (mem_rvalid_i & w_tag_v) ? (ONE_HOT0 << w_tag_p) : '0;
  assign mem_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (mem_rvalid_i != w_tag_v) begin
      r_err <= 1'b1;
    end
  end

  assign ptr_o = r_ptr;
  assign err_o = r_err;

endmodule

// File: tb/tb_mem_read_rr_arbiter.sv
// Directed bench for mem_read_rr_arbiter. Instance A uses READ_LAT=1,
// MAX_BURST=1; instance B uses READ_LAT=3, MAX_BURST=3. Inputs change 1 ns
// after the rising edge and outputs are checked 1 ns later.
module tb_mem_read_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance A
  logic [3:0]  a_re = '0;
  logic [39:0] a_addr = '0;
  logic [3:0]  a_gnt;
  logic        a_ready = 1'b1;
  logic        a_re_o;
  logic [9:0]  a_raddr;
  logic        a_rv_i = 1'b0;
  logic [15:0] a_rd_i = '0;
  logic [3:0]  a_rv_o;
  logic [15:0] a_rd_o;
  logic [1:0]  a_ptr;
  logic        a_err;

  // instance B
  logic [3:0]  b_re = '0;
  logic [39:0] b_addr = '0;
  logic [3:0]  b_gnt;
  logic        b_ready = 1'b0;
  logic        b_re_o;
  logic [9:0]  b_raddr;
  logic        b_rv_i = 1'b0;
  logic [15:0] b_rd_i = '0;
  logic [3:0]  b_rv_o;
  logic [15:0] b_rd_o;
  logic [1:0]  b_ptr;
  logic        b_err;

  mem_read_rr_arbiter #(.N(4), .ADDR_W(10), .BLOCK_BITS(16), .READ_LAT(1), .MAX_BURST(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_re_i(a_re), .mem_raddr_i(a_addr), .mem_gnt_o(a_gnt),
    .mem_ready_i(a_ready), .mem_re_o(a_re_o), .mem_raddr_o(a_raddr),
    .mem_rvalid_i(a_rv_i), .mem_rdata_i(a_rd_i),
    .mem_rvalid_o(a_rv_o), .mem_rdata_o(a_rd_o),
    .ptr_o(a_ptr), .err_o(a_err)
  );

  mem_read_rr_arbiter #(.N(4), .ADDR_W(10), .BLOCK_BITS(16), .READ_LAT(3), .MAX_BURST(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_re_i(b_re), .mem_raddr_i(b_addr), .mem_gnt_o(b_gnt),
    .mem_ready_i(b_ready), .mem_re_o(b_re_o), .mem_raddr_o(b_raddr),
    .mem_rvalid_i(b_rv_i), .mem_rdata_i(b_rd_i),
    .mem_rvalid_o(b_rv_o), .mem_rdata_o(b_rd_o),
    .ptr_o(b_ptr), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return (p < 0) ? 4'b0000 : (one << p);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Burst schedule for B: ready per cycle and expected granted port (-1 = none).
  int          bg [0:13] = '{0, 0, -1, -1, 0, 1, 1, 1, 0, 0, 0, -1, -1, -1};
  logic        br [0:13] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [1:0]  bp [0:13] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1, 1, 1};

  initial begin
    int g;
    int prev;

    // ---- reset state, grants gated while rst_n=0
    #2;
    a_re = 4'b1111;
    #1;
    chk("rst_ptr", 64'(a_ptr), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_gnt", 64'(a_gnt), 64'd0);
    chk("rst_re_o", 64'(a_re_o), 64'd0);
    chk("rst_rv_o", 64'(a_rv_o), 64'd0);
    $display("[TB] reset: gnt=%b re_o=%b ptr=%0d", a_gnt, a_re_o, a_ptr);
    a_re = '0;
    next_cycle();
    rst_n = 1'b1;

    // ---- single port 2, addr 0x05
    next_cycle();
    a_addr = {10'h000, 10'h005, 10'h000, 10'h000};
    a_re = 4'b0100;
    #1;
    chk("single_gnt", 64'(a_gnt), 64'(4'b0100));
    chk("single_raddr", 64'(a_raddr), 64'h05);
    chk("single_re_o", 64'(a_re_o), 64'd1);
    $display("[TB] single: gnt=%b raddr=%0h", a_gnt, a_raddr);
    next_cycle();
    a_re = '0;
    a_rv_i = 1'b1;
    a_rd_i = 16'h00AB;
    #1;
    chk("single_rv_o", 64'(a_rv_o), 64'(4'b0100));
    chk("single_rdata", 64'(a_rd_o), 64'h00AB);
    chk("single_ptr", 64'(a_ptr), 64'd3);
    chk("idle_gnt", 64'(a_gnt), 64'd0);
    chk("idle_raddr", 64'(a_raddr), 64'd0);
    $display("[TB] single resp: rv_o=%b rdata=%0h ptr=%0d", a_rv_o, a_rd_o, a_ptr);
    next_cycle();
    a_rv_i = 1'b0;

    // ---- all four request continuously, ptr=3 -> 3,0,1,2,3,0
    a_addr = {10'h013, 10'h012, 10'h011, 10'h010};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      a_re = 4'b1111;
      a_rv_i = (c > 0);
      #1;
      g = (3 + c) % 4;
      prev = (3 + c - 1) % 4;
      chk("rr_gnt", 64'(a_gnt), 64'(oh(g)));
      chk("rr_raddr", 64'(a_raddr), 64'(10'h010 + g));
      chk("rr_rv_o", 64'(a_rv_o), 64'((c > 0) ? oh(prev) : 4'b0000));
      $display("[TB] rr c=%0d: gnt=%b raddr=%0h rv_o=%b", c, a_gnt, a_raddr, a_rv_o);
    end
    next_cycle();
    a_re = '0;
    a_rv_i = 1'b1;
    #1;
    chk("rr_last_rv_o", 64'(a_rv_o), 64'(oh(0)));
    chk("rr_ptr", 64'(a_ptr), 64'd1);
    $display("[TB] rr tail: rv_o=%b ptr=%0d", a_rv_o, a_ptr);
    next_cycle();
    a_rv_i = 1'b0;

    // ---- idle skip: ports 1 and 3 -> 1,3,1,3
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      a_re = 4'b1010;
      a_rv_i = (c > 0);
      #1;
      g = (c % 2 == 1) ? 3 : 1;
      prev = (c % 2 == 1) ? 1 : 3;
      chk("skip_gnt", 64'(a_gnt), 64'(oh(g)));
      chk("skip_rv_o", 64'(a_rv_o), 64'((c > 0) ? oh(prev) : 4'b0000));
      $display("[TB] skip c=%0d: gnt=%b rv_o=%b", c, a_gnt, a_rv_o);
    end
    next_cycle();
    a_re = '0;
    a_rv_i = 1'b1;
    #1;
    chk("skip_last_rv_o", 64'(a_rv_o), 64'(oh(3)));
    chk("skip_ptr", 64'(a_ptr), 64'd0);
    next_cycle();
    a_rv_i = 1'b0;
    #1;
    chk("skip_err", 64'(a_err), 64'd0);
    $display("[TB] skip tail: ptr=%0d err=%b", a_ptr, a_err);

    // ---- spurious response on A
    next_cycle();
    a_rv_i = 1'b1;
    #1;
    chk("spur_rv_o", 64'(a_rv_o), 64'd0);
    next_cycle();
    a_rv_i = 1'b0;
    #1;
    chk("spur_err", 64'(a_err), 64'd1);
    next_cycle();
    next_cycle();
    chk("spur_err_sticky", 64'(a_err), 64'd1);
    $display("[TB] spurious: err=%b", a_err);

    // ---- reset mid-operation on A
    next_cycle();
    a_re = 4'b1111;
    next_cycle();
    a_rv_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", 64'(a_gnt), 64'd0);
    chk("mrst_re_o", 64'(a_re_o), 64'd0);
    chk("mrst_rv_o", 64'(a_rv_o), 64'd0);
    chk("mrst_ptr", 64'(a_ptr), 64'd0);
    chk("mrst_err", 64'(a_err), 64'd0);
    $display("[TB] mid reset: gnt=%b rv_o=%b ptr=%0d err=%b", a_gnt, a_rv_o, a_ptr, a_err);
    next_cycle();
    a_re = '0;
    a_rv_i = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    chk("mrst_stale_rv_o", 64'(a_rv_o), 64'd0);
    a_addr = {10'h000, 10'h077, 10'h000, 10'h000};
    a_re = 4'b0100;
    #1;
    chk("mrst_new_gnt", 64'(a_gnt), 64'(4'b0100));
    chk("mrst_new_raddr", 64'(a_raddr), 64'h77);
    next_cycle();
    a_re = '0;
    a_rv_i = 1'b1;
    #1;
    chk("mrst_new_rv_o", 64'(a_rv_o), 64'(4'b0100));
    $display("[TB] after reset: rv_o=%b", a_rv_o);
    next_cycle();
    a_rv_i = 1'b0;

    // ---- B: burst of 3 with a two-cycle ready stall, READ_LAT=3
    b_addr = {10'h0B3, 10'h0B2, 10'h0B1, 10'h0B0};
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      b_re = (c < 11) ? 4'b0011 : 4'b0000;
      b_ready = br[c];
      b_rv_i = (c >= 3) && (bg[c-3] >= 0);
      #1;
      chk("burst_gnt", 64'(b_gnt), 64'(oh(bg[c])));
      chk("burst_ptr", 64'(b_ptr), 64'(bp[c]));
      chk("burst_rv_o", 64'(b_rv_o), 64'((c >= 3) ? oh(bg[c-3]) : 4'b0000));
      $display("[TB] burst c=%0d: gnt=%b ptr=%0d rv_o=%b", c, b_gnt, b_ptr, b_rv_o);
    end
    next_cycle();
    b_rv_i = 1'b0;
    #1;
    chk("burst_err", 64'(b_err), 64'd0);

    // ---- B: back-to-back grants 3 then 0, responses at t+3 and t+4
    next_cycle();
    b_re = 4'b1000;
    #1;
    chk("lat_gnt3", 64'(b_gnt), 64'(oh(3)));
    next_cycle();
    b_re = 4'b0001;
    #1;
    chk("lat_gnt0", 64'(b_gnt), 64'(oh(0)));
    next_cycle();
    b_re = '0;
    next_cycle();
    b_rv_i = 1'b1;
    b_rd_i = 16'h3333;
    #1;
    chk("lat_rv3", 64'(b_rv_o), 64'(oh(3)));
    chk("lat_rdata", 64'(b_rd_o), 64'h3333);
    next_cycle();
    #1;
    chk("lat_rv0", 64'(b_rv_o), 64'(oh(0)));
    $display("[TB] latency: rv_o=%b", b_rv_o);
    next_cycle();
    #1;
    chk("lat_spur_rv_o", 64'(b_rv_o), 64'd0);
    next_cycle();
    b_rv_i = 1'b0;
    #1;
    chk("lat_spur_err", 64'(b_err), 64'd1);
    next_cycle();
    next_cycle();
    chk("lat_err_sticky", 64'(b_err), 64'd1);
    $display("[TB] latency spurious: err=%b", b_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
